if_fetch_stage: RTL and testbench

- Instruction-fetch pipeline stage that sits directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one request at a time to the instruction memory over a valid/ready request and response handshake.
- Packs {Instruction, PC} onto the IF→ID bus.
- Takes branch and jump redirects from decode and squashes any wrong-path fetch, whether it is in flight or already held.

---
 rtl/if_fetch_stage_pkg.sv | 32 +++
 rtl/if_fetch_stage_if.sv | 28 ++
 rtl/if_fetch_stage.sv | 99 +++++++++
 tb/tb_if_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, bus payload layouts and FSM encoding for the fetch stage.
package if_fetch_stage_pkg;

   localparam int unsigned IF_TO_ID_BUS_WD = 64;
   localparam int unsigned BRJ_BUS_WD      = 33;
   localparam int unsigned ID_TO_EX_BUS_WD = 159;
   localparam int unsigned RDW_BUS_WD      = 38;
   localparam int unsigned XLEN            = 32;

   localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

   // IF->ID payload: {Instruction, PC}
   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } if_to_id_bus_t;

   // Redirect payload from decode: {wen, target}
   typedef struct packed {
      logic            wen;
      logic [XLEN-1:0] target;
   } brj_bus_t;

   // One-hot fetch states
   typedef enum logic [3:0] {
      S_INIT = 4'b0001,
      S_IF   = 4'b0010,
      S_IW   = 4'b0100,
      S_HOLD = 4'b1000
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage handshake bundle: decode side, redirect input and imem request/response.
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic                       ID_Allow_in;
   logic                       IF_to_ID_Valid;
   logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_Bus;
   logic [BRJ_BUS_WD-1:0]      Branch_or_Jump_Bus;
   logic [XLEN-1:0]            PC;
   logic                       Inst_Req_Valid;
   logic                       Inst_Req_Ready;
   logic [XLEN-1:0]            Instruction;
   logic                       Inst_Valid;
   logic                       Inst_Ready;

   // Fetch stage side
   modport master (
      input  ID_Allow_in, Branch_or_Jump_Bus, Inst_Req_Ready, Instruction, Inst_Valid,
      output IF_to_ID_Valid, IF_to_ID_Bus, PC, Inst_Req_Valid, Inst_Ready
   );

   // Environment side (decode + instruction memory)
   modport slave (
      output ID_Allow_in, Branch_or_Jump_Bus, Inst_Req_Ready, Instruction, Inst_Valid,
      input  IF_to_ID_Valid, IF_to_ID_Bus, PC, Inst_Req_Valid, Inst_Ready
   );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time,
// hands {inst, pc} to decode and squashes wrong-path fetches on redirect.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic             clk,
   input  logic             rst,
   if_fetch_stage_if.master fbus
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] inst_buf;
   logic            redir_pend;
   logic            cancel;

   brj_bus_t        brj;
   logic            redirect_now;
   if_to_id_bus_t   out_bus;

   // Redirect is only trusted when decode is retiring the branch this cycle
   assign brj          = brj_bus_t'(fbus.Branch_or_Jump_Bus);
   assign redirect_now = brj.wen & fbus.ID_Allow_in;

   // Handshake outputs decode straight from the state flops; valid is killed by a same-cycle redirect
   assign fbus.PC             = pc;
   assign fbus.Inst_Req_Valid = (state == S_IF);
   assign fbus.Inst_Ready     = (state == S_IW);
   assign fbus.IF_to_ID_Valid = (state == S_HOLD) & ~redirect_now;
   assign out_bus.inst        = inst_buf;
   assign out_bus.pc          = pc;
   assign fbus.IF_to_ID_Bus   = IF_TO_ID_BUS_WD'(out_bus);

   // Fetch FSM and PC / redirect bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_INIT;
         pc         <= RESET_PC;
         redir_pc   <= RESET_PC;
         inst_buf   <= '0;
         redir_pend <= 1'b0;
         cancel     <= 1'b0;
      end else begin
         unique case (state)
            S_INIT: begin
               state <= S_IF;
            end
            S_IF: begin
               // PC must stay put while the request is up; remember the redirect instead
               if (redirect_now) begin
                  redir_pend <= 1'b1;
                  redir_pc   <= brj.target;
                  cancel     <= 1'b1;
               end
               if (fbus.Inst_Req_Ready) begin
                  state <= S_IW;
               end
            end
            S_IW: begin
               if (fbus.Inst_Valid) begin
                  if (redirect_now) begin
                     // Response arrives with the redirect: drop it and jump now
                     pc         <= brj.target;
                     redir_pend <= 1'b0;
                     cancel     <= 1'b0;
                     state      <= S_IF;
                  end else if (cancel) begin
                     // Wrong-path response: discard and resume at the saved target
                     pc         <= redir_pc;
                     redir_pend <= 1'b0;
                     cancel     <= 1'b0;
                     state      <= S_IF;
                  end else begin
                     inst_buf <= fbus.Instruction;
                     state    <= S_HOLD;
                  end
               end else if (redirect_now) begin
                  redir_pend <= 1'b1;
                  redir_pc   <= brj.target;
                  cancel     <= 1'b1;
               end
            end
            S_HOLD: begin
               if (fbus.ID_Allow_in) begin
                  pc    <= redirect_now ? brj.target : pc + 32'd4;
                  state <= S_IF;
               end
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs driven #1 after each rising edge,
// outputs checked with immediate assertions a further #1 later.
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   if_fetch_stage_if fb ();

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk  (clk),
      .rst  (rst),
      .fbus (fb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // req_valid / inst_ready / id_valid in one call
   task automatic chk_hs(input string tag, input logic rv, input logic ir, input logic iv);
      chk_bit({tag, ".req_valid"}, fb.Inst_Req_Valid, rv);
      chk_bit({tag, ".inst_ready"}, fb.Inst_Ready, ir);
      chk_bit({tag, ".id_valid"}, fb.IF_to_ID_Valid, iv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decode must never issue a second redirect while one is still pending
   always @(negedge clk) begin
      if (rst && dut.redir_pend && fb.Branch_or_Jump_Bus[32] && fb.ID_Allow_in) begin
         errors++;
         $error("FAIL double_redirect observed=1 expected=0");
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      fb.ID_Allow_in        = 1'b1;
      fb.Branch_or_Jump_Bus = '0;
      fb.Inst_Req_Ready     = 1'b1;
      fb.Instruction        = '0;
      fb.Inst_Valid         = 1'b1;
      #1;
      chk_hs("reset", 1'b0, 1'b0, 1'b0);
      chk_word("reset.pc", fb.PC, 32'h0);
      tick();
      tick();
      rst = 1'b1;

      // Release -> INIT->IF->IW->HOLD; first valid on the 4th edge counting the release edge
      tick();
      chk_hs("boot.if", 1'b1, 1'b0, 1'b0);
      chk_word("boot.if.pc", fb.PC, 32'h0);
      tick();
      chk_hs("boot.iw", 1'b0, 1'b1, 1'b0);
      fb.Instruction = mem(32'h0);
      tick();
      chk_hs("boot.hold", 1'b0, 1'b0, 1'b1);
      chk_bus("boot.bus", fb.IF_to_ID_Bus, {mem(32'h0), 32'h0});
      tick();
      chk_word("seq.pc4", fb.PC, 32'h4);
      chk_hs("seq.if4", 1'b1, 1'b0, 1'b0);

      // Request stall: PC and request held while memory is not ready
      fb.Inst_Req_Ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_word("stall.pc", fb.PC, 32'h4);
         chk_bit("stall.req_valid", fb.Inst_Req_Valid, 1'b1);
      end
      fb.Inst_Req_Ready = 1'b1;
      tick();
      chk_hs("stall.iw", 1'b0, 1'b1, 1'b0);
      fb.Instruction = mem(32'h4);
      tick();
      chk_bus("stall.bus", fb.IF_to_ID_Bus, {mem(32'h4), 32'h4});
      tick();
      chk_word("seq.pc8", fb.PC, 32'h8);
      tick();
      fb.Instruction = mem(32'h8);
      tick();
      chk_bus("seq.bus8", fb.IF_to_ID_Bus, {mem(32'h8), 32'h8});

      // Decode back-pressure in HOLD
      fb.ID_Allow_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_bus("bp.bus", fb.IF_to_ID_Bus, {mem(32'h8), 32'h8});
         chk_hs("bp", 1'b0, 1'b0, 1'b1);
      end
      fb.ID_Allow_in = 1'b1;
      tick();
      chk_word("bp.next_pc", fb.PC, 32'hC);
      chk_hs("bp.if", 1'b1, 1'b0, 1'b0);
      tick();
      fb.Instruction = mem(32'hC);
      tick();
      chk_bus("seq.busC", fb.IF_to_ID_Bus, {mem(32'hC), 32'hC});
      tick();
      chk_word("seq.pc10", fb.PC, 32'h10);

      // Redirect in IW, wrong-path response three cycles later
      fb.Inst_Valid = 1'b0;
      tick();
      chk_hs("rdiw.iw", 1'b0, 1'b1, 1'b0);
      fb.Branch_or_Jump_Bus = {1'b1, 32'h0000_0100};
      tick();
      fb.Branch_or_Jump_Bus = '0;
      tick();
      tick();
      chk_hs("rdiw.wait", 1'b0, 1'b1, 1'b0);
      fb.Inst_Valid  = 1'b1;
      fb.Instruction = mem(32'h10);
      tick();
      chk_hs("rdiw.drop", 1'b1, 1'b0, 1'b0);
      chk_word("rdiw.pc", fb.PC, 32'h100);
      tick();
      fb.Instruction = mem(32'h100);
      tick();
      chk_bus("rdiw.bus", fb.IF_to_ID_Bus, {mem(32'h100), 32'h100});
      tick();
      chk_word("seq.pc104", fb.PC, 32'h104);

      // Redirect in HOLD kills the held instruction in the same cycle
      tick();
      fb.Instruction = mem(32'h104);
      tick();
      chk_bit("rdhold.pre", fb.IF_to_ID_Valid, 1'b1);
      fb.Branch_or_Jump_Bus = {1'b1, 32'h0000_0200};
      #1;
      chk_bit("rdhold.kill", fb.IF_to_ID_Valid, 1'b0);
      tick();
      fb.Branch_or_Jump_Bus = '0;
      chk_word("rdhold.pc", fb.PC, 32'h200);

      // Redirect in IF: request completes, response dropped
      fb.Branch_or_Jump_Bus = {1'b1, 32'h0000_0300};
      tick();
      fb.Branch_or_Jump_Bus = '0;
      chk_word("rdif.pc_held", fb.PC, 32'h200);
      fb.Instruction = mem(32'h200);
      tick();
      chk_hs("rdif.drop", 1'b1, 1'b0, 1'b0);
      chk_word("rdif.pc", fb.PC, 32'h300);

      // Redirect together with the response in IW
      tick();
      fb.Branch_or_Jump_Bus = {1'b1, 32'h0000_0400};
      fb.Instruction = mem(32'h300);
      tick();
      fb.Branch_or_Jump_Bus = '0;
      chk_hs("rdboth", 1'b1, 1'b0, 1'b0);
      chk_word("rdboth.pc", fb.PC, 32'h400);

      // PC+4 wraps at the top of the address space
      tick();
      fb.Instruction = mem(32'h400);
      tick();
      fb.Branch_or_Jump_Bus = {1'b1, 32'hFFFF_FFFC};
      tick();
      fb.Branch_or_Jump_Bus = '0;
      chk_word("wrap.top", fb.PC, 32'hFFFF_FFFC);
      tick();
      fb.Instruction = mem(32'hFFFF_FFFC);
      tick();
      chk_bus("wrap.bus", fb.IF_to_ID_Bus, {mem(32'hFFFF_FFFC), 32'hFFFF_FFFC});
      tick();
      chk_word("wrap.pc", fb.PC, 32'h0);

      // Asynchronous reset in IW, then restart from the reset PC
      tick();
      chk_hs("arst.iw", 1'b0, 1'b1, 1'b0);
      fb.Inst_Valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk_hs("arst", 1'b0, 1'b0, 1'b0);
      chk_word("arst.pc", fb.PC, 32'h0);
      tick();
      rst = 1'b1;
      fb.Inst_Valid = 1'b1;
      tick();
      chk_hs("arst.if", 1'b1, 1'b0, 1'b0);
      chk_word("arst.if.pc", fb.PC, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
